// File: rtl/step3_action_select.sv
// PBVI step 3: per-belief argmax over backed-up action vectors.
// The result is written back as the new alpha set, followed by a kick to step 1.
module step3_action_select #(
  parameter int unsigned N_BELIEF = 16,
  parameter int unsigned N_ACTION = 3,
  parameter int unsigned W        = 16,
  parameter int unsigned BIDX_W   = 4,
  parameter int unsigned AIDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      gamma_action_belief [0:N_ACTION-1][0:N_BELIEF-1][0:1],
  input  logic [W-1:0]      point_belief        [0:N_BELIEF-1][0:1],
  output logic [W-1:0]      alpha_out           [0:N_BELIEF-1][0:1],
  output logic [AIDX_W-1:0] action_out          [0:N_BELIEF-1],
  output logic [W-1:0]      value_out           [0:N_BELIEF-1],
  output logic              busy,
  output logic              done,
  output logic              en_step1
);

  localparam int unsigned PW = 2 * W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [BIDX_W-1:0] b_q;
  logic [BIDX_W-1:0] bd_q;
  logic              vld_q;

  logic [W-1:0]      g_snap  [0:N_ACTION-1][0:N_BELIEF-1][0:1];
  logic [W-1:0]      pb_snap [0:N_BELIEF-1][0:1];

  logic [PW-1:0]     prod_c  [0:N_ACTION-1];
  logic [W-1:0]      dot_c   [0:N_ACTION-1];
  logic [W-1:0]      dot_q   [0:N_ACTION-1];

  logic [AIDX_W-1:0] best_a_c;
  logic [W-1:0]      best_v_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (b_q == BIDX_W'(N_BELIEF - 1)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: two-term dot product per action, sum wraps mod 2^PW, keep the high half.
  always_comb begin
    for (int unsigned a = 0; a < N_ACTION; a++) begin
      prod_c[a] = PW'(g_snap[a][b_q][0]) * PW'(pb_snap[b_q][0])
                + PW'(g_snap[a][b_q][1]) * PW'(pb_snap[b_q][1]);
      dot_c[a]  = prod_c[a][PW-1:W];
    end
  end

  // Stage 2: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_a_c = '0;
    best_v_c = dot_q[0];
    for (int unsigned a = 1; a < N_ACTION; a++) begin
      if (dot_q[a] > best_v_c) begin
        best_a_c = AIDX_W'(a);
        best_v_c = dot_q[a];
      end
    end
  end

  // Input snapshot is pure datapath; it is only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && en && !rst) begin
      g_snap  <= gamma_action_belief;
      pb_snap <= point_belief;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q      <= '0;
      bd_q     <= '0;
      vld_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_step1 <= 1'b0;
      for (int unsigned a = 0; a < N_ACTION; a++) dot_q[a] <= '0;
      for (int unsigned k = 0; k < N_BELIEF; k++) begin
        alpha_out[k][0] <= '0;
        alpha_out[k][1] <= '0;
        action_out[k]   <= '0;
        value_out[k]    <= '0;
      end
    end else begin
      vld_q    <= (state == S_RUN);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state == S_DRAIN);
      en_step1 <= (state == S_DRAIN);
      if (state == S_IDLE && en) b_q <= '0;
      if (state == S_RUN) begin
        dot_q <= dot_c;
        bd_q  <= b_q;
        b_q   <= b_q + 1'b1;
      end
      if (vld_q) begin
        alpha_out[bd_q][0] <= g_snap[best_a_c][bd_q][0];
        alpha_out[bd_q][1] <= g_snap[best_a_c][bd_q][1];
        action_out[bd_q]   <= best_a_c;
        value_out[bd_q]    <= best_v_c;
      end
    end
  end

endmodule

// File: tb/tb_step3_action_select.sv
// Testbench for step3_action_select: directed and random runs checked against
// an arithmetic model of the per-belief argmax, including cycle-exact timing.
module tb_step3_action_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] g  [0:2][0:15][0:1];
  logic [15:0] pb [0:15][0:1];
  logic [15:0] alpha_out  [0:15][0:1];
  logic [1:0]  action_out [0:15];
  logic [15:0] value_out  [0:15];
  logic        busy, done, en_step1;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs currently held (m_*) and after the run in progress (n_*).
  logic [15:0] m_alpha [0:15][0:1];
  logic [1:0]  m_act   [0:15];
  logic [15:0] m_val   [0:15];
  logic [15:0] n_alpha [0:15][0:1];
  logic [1:0]  n_act   [0:15];
  logic [15:0] n_val   [0:15];

  step3_action_select dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .gamma_action_belief (g),
    .point_belief        (pb),
    .alpha_out           (alpha_out),
    .action_out          (action_out),
    .value_out           (value_out),
    .busy                (busy),
    .done                (done),
    .en_step1            (en_step1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Value of belief b under action a: fixed-point dot product, wrapped to 32 bits.
  function automatic longint unsigned dot_val(input int a, input int b);
    longint unsigned s;
    s = longint'(g[a][b][0]) * longint'(pb[b][0]) + longint'(g[a][b][1]) * longint'(pb[b][1]);
    return (s % 64'h1_0000_0000) / 65536;
  endfunction

  task automatic compute_new();
    for (int b = 0; b < 16; b++) begin
      longint unsigned best_v;
      int best_a;
      best_v = dot_val(0, b);
      best_a = 0;
      for (int a = 1; a < 3; a++) begin
        if (dot_val(a, b) > best_v) begin
          best_v = dot_val(a, b);
          best_a = a;
        end
      end
      n_act[b]      = 2'(best_a);
      n_val[b]      = 16'(best_v);
      n_alpha[b][0] = g[best_a][b][0];
      n_alpha[b][1] = g[best_a][b][1];
    end
  endtask

  task automatic zero_model();
    for (int k = 0; k < 16; k++) begin
      m_alpha[k][0] = '0;
      m_alpha[k][1] = '0;
      m_act[k]      = '0;
      m_val[k]      = '0;
    end
  endtask

  task automatic chk_entry(input string tag, input int k, input bit use_new);
    chk({tag, "_alpha0"}, k, alpha_out[k][0], use_new ? n_alpha[k][0] : m_alpha[k][0]);
    chk({tag, "_alpha1"}, k, alpha_out[k][1], use_new ? n_alpha[k][1] : m_alpha[k][1]);
    chk({tag, "_action"}, k, action_out[k],   use_new ? n_act[k]      : m_act[k]);
    chk({tag, "_value"},  k, value_out[k],    use_new ? n_val[k]      : m_val[k]);
  endtask

  task automatic randomize_inputs(input bit gamma_only);
    for (int b = 0; b < 16; b++) begin
      for (int s = 0; s < 2; s++) begin
        for (int a = 0; a < 3; a++) g[a][b][s] = 16'($urandom);
        if (!gamma_only) pb[b][s] = 16'($urandom);
      end
    end
  endtask

  // One run started in c0; cycle c is observed just after the edge that ends c-1.
  task automatic run(input bit extra_en, input int chg_at, input int rst_at);
    compute_new();
    en = 1'b1;
    step();
    en = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk("busy",     c, busy,     32'(c <= 18));
      chk("done",     c, done,     32'(c == 18));
      chk("en_step1", c, en_step1, 32'(c == 18));
      for (int k = 0; k < 16; k++) chk_entry("run", k, c >= k + 3);
      if (c == 19) break;
      en = extra_en && (c == 5 || c == 18);
      if (c == chg_at) randomize_inputs(1'b0);
      if (c == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b0;
        zero_model();
        for (int k = 0; k < 16; k++) chk_entry("abort", k, 1'b0);
        for (int i = 0; i < 12; i++) begin
          chk("abort_busy", i, busy, 0);
          chk("abort_done", i, done, 0);
          chk("abort_en1",  i, en_step1, 0);
          step();
        end
        return;
      end
      step();
    end
    en = 1'b0;
    m_alpha = n_alpha;
    m_act   = n_act;
    m_val   = n_val;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    zero_model();
    for (int b = 0; b < 16; b++) begin
      pb[b][0] = '0;
      pb[b][1] = '0;
      for (int a = 0; a < 3; a++) begin
        g[a][b][0] = '0;
        g[a][b][1] = '0;
      end
    end

    // Reset, with en held high that must not start a run.
    step();
    step();
    for (int k = 0; k < 16; k++) chk_entry("reset", k, 1'b0);
    chk("reset_busy", 0, busy, 0);
    chk("reset_done", 0, done, 0);
    chk("reset_en1",  0, en_step1, 0);
    rst = 1'b0;
    en  = 1'b0;
    step();
    step();
    chk("post_reset_busy", 0, busy, 0);
    chk("post_reset_done", 0, done, 0);

    // Half/half belief: action 2 wins with value 150.
    for (int b = 0; b < 16; b++) begin
      pb[b][0] = 16'h8000;  pb[b][1] = 16'h8000;
      g[0][b][0] = 16'd100; g[0][b][1] = 16'd100;
      g[1][b][0] = 16'd200; g[1][b][1] = 16'd0;
      g[2][b][0] = 16'd0;   g[2][b][1] = 16'd300;
    end
    run(1'b0, 0, 0);
    for (int k = 0; k < 16; k += 5) begin
      chk("t2_action", k, action_out[k], 2);
      chk("t2_value",  k, value_out[k], 150);
      chk("t2_alpha1", k, alpha_out[k][1], 300);
    end

    // Three-way tie resolves to action 0.
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 3; a++) begin
        g[a][b][0] = 16'd50;
        g[a][b][1] = 16'd50;
      end
    run(1'b0, 0, 0);
    for (int k = 0; k < 16; k += 5) begin
      chk("t3_action", k, action_out[k], 0);
      chk("t3_value",  k, value_out[k], 50);
    end

    // Timing with spurious en pulses in c5 and c18.
    randomize_inputs(1'b0);
    run(1'b1, 0, 0);

    // Abort by reset in c8, then a clean run.
    randomize_inputs(1'b0);
    run(1'b0, 0, 8);
    randomize_inputs(1'b0);
    run(1'b0, 0, 0);

    // Overflowing products on even beliefs, inputs scrambled in c3.
    randomize_inputs(1'b0);
    for (int b = 0; b < 16; b += 2) begin
      pb[b][0] = 16'hFFFF; pb[b][1] = 16'hFFFF;
      for (int a = 0; a < 3; a++) begin
        g[a][b][0] = 16'hFFFF;
        g[a][b][1] = 16'hFFFF;
      end
    end
    run(1'b0, 3, 0);
    chk("wrap_value",  0, value_out[0], 32'h0000_FFFC);
    chk("wrap_action", 0, action_out[0], 0);
    chk("wrap_value",  14, value_out[14], 32'h0000_FFFC);

    // Back-to-back random runs.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1'b0);
      run(1'b0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
